unidade_acesso_memoria: RTL and testbench

- Initiator side of the data-memory interface: the load/store controller that drives the word-addressed, registered-read data memory.
- Accepts byte-addressed load/store requests from the datapath over a valid/ready handshake. Translates them to word index plus WriteMem/ReadMem strobes.
- Performs sub-word stores by read-modify-write and returns load data, sign- or zero-extended, over a valid/ready response channel.

---
 rtl/unidade_acesso_memoria.sv | 239 +++++++++++++++++++++++
 tb/tb_unidade_acesso_memoria.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_acesso_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : unidade_acesso_memoria                                        |
// | Purpose  : load/store controller for a word-addressed, registered-read   |
// |            data memory; sub-word access enabled by ACESSO_SUBPALAVRA_EN  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module unidade_acesso_memoria #(
  parameter int          PROFUNDIDADE  = 16,
  parameter logic [31:0] ENDERECO_BASE = 32'h0
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqEscrita,
  input  logic [1:0]  ReqTamanho,
  input  logic        ReqSinal,
  input  logic [31:0] ReqEndereco,
  input  logic [31:0] ReqDado,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespDado,
  output logic        RespErro,
  output logic [31:0] Endereco,
  output logic [31:0] EscreveDado,
  output logic        WriteMem,
  output logic        ReadMem,
  input  logic [31:0] DadosLeitura
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LE       = 3'd1,
    CAPTURA  = 3'd2,
    ESCREVE  = 3'd3,
    RESPOSTA = 3'd4
  } estado_t;

  localparam logic [1:0]  c_BYTE         = 2'b00;
  localparam logic [1:0]  c_MEIA         = 2'b01;
  localparam logic [1:0]  c_PALAVRA      = 2'b10;
  localparam logic [31:0] c_PROFUNDIDADE = 32'(PROFUNDIDADE);

  estado_t     estado_q, estado_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_erro_q, resp_erro_d;
  logic [31:0] resp_dado_q, resp_dado_d;
  logic [31:0] endereco_q, endereco_d;
  logic [31:0] escreve_dado_q, escreve_dado_d;
  logic        write_mem_q, write_mem_d;
  logic        read_mem_q, read_mem_d;

  logic [31:0] w_off;
  logic [31:0] w_indice;
  logic        w_erro;

  assign w_off    = ReqEndereco - ENDERECO_BASE;
  assign w_indice = {2'b00, w_off[31:2]};

`ifdef ACESSO_SUBPALAVRA_EN
  logic        escrita_q, escrita_d;
  logic [1:0]  tamanho_q, tamanho_d;
  logic        sinal_q, sinal_d;
  logic [31:0] dado_q, dado_d;
  logic [1:0]  lane_q, lane_d;

  logic [15:0] w_meia;
  logic [7:0]  w_byte;
  logic [31:0] w_extraido;
  logic [31:0] w_mascara;
  logic [31:0] w_novo;
  logic [31:0] w_mesclado;

  // Shifting the selected lane down to bit 0 serves both byte and halfword.
  assign w_meia = 16'(DadosLeitura >> {lane_q, 3'b000});
  assign w_byte = w_meia[7:0];

  always_comb begin
    w_extraido = DadosLeitura;
    w_mascara  = 32'hFFFF_FFFF;
    w_novo     = dado_q;
    case (tamanho_q)
      c_BYTE: begin
        w_extraido = {{24{sinal_q & w_byte[7]}}, w_byte};
        w_mascara  = 32'h0000_00FF << {lane_q, 3'b000};
        w_novo     = {24'h0, dado_q[7:0]} << {lane_q, 3'b000};
      end
      c_MEIA: begin
        w_extraido = {{16{sinal_q & w_meia[15]}}, w_meia};
        w_mascara  = 32'h0000_FFFF << {lane_q, 3'b000};
        w_novo     = {16'h0, dado_q[15:0]} << {lane_q, 3'b000};
      end
      default: ;
    endcase
    w_mesclado = (DadosLeitura & ~w_mascara) | (w_novo & w_mascara);
  end
`else
  logic unused_sinal;
  assign unused_sinal = ReqSinal;
`endif

  always_comb begin
    w_erro = 1'b0;
    case (ReqTamanho)
`ifdef ACESSO_SUBPALAVRA_EN
      c_BYTE:    w_erro = 1'b0;
      c_MEIA:    w_erro = w_off[0];
`else
      c_BYTE,
      c_MEIA:    w_erro = 1'b1;
`endif
      c_PALAVRA: w_erro = |w_off[1:0];
      default:   w_erro = 1'b1;
    endcase
    if (w_indice >= c_PROFUNDIDADE) begin
      w_erro = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q       <= OCIOSO;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_erro_q    <= 1'b0;
      resp_dado_q    <= 32'h0;
      endereco_q     <= 32'h0;
      escreve_dado_q <= 32'h0;
      write_mem_q    <= 1'b0;
      read_mem_q     <= 1'b0;
`ifdef ACESSO_SUBPALAVRA_EN
      escrita_q      <= 1'b0;
      tamanho_q      <= 2'b00;
      sinal_q        <= 1'b0;
      dado_q         <= 32'h0;
      lane_q         <= 2'b00;
`endif
    end else begin
      estado_q       <= estado_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_erro_q    <= resp_erro_d;
      resp_dado_q    <= resp_dado_d;
      endereco_q     <= endereco_d;
      escreve_dado_q <= escreve_dado_d;
      write_mem_q    <= write_mem_d;
      read_mem_q     <= read_mem_d;
`ifdef ACESSO_SUBPALAVRA_EN
      escrita_q      <= escrita_d;
      tamanho_q      <= tamanho_d;
      sinal_q        <= sinal_d;
      dado_q         <= dado_d;
      lane_q         <= lane_d;
`endif
    end
  end

  always_comb begin
    estado_d       = estado_q;
    resp_erro_d    = resp_erro_q;
    resp_dado_d    = resp_dado_q;
    endereco_d     = endereco_q;
    escreve_dado_d = escreve_dado_q;
`ifdef ACESSO_SUBPALAVRA_EN
    escrita_d      = escrita_q;
    tamanho_d      = tamanho_q;
    sinal_d        = sinal_q;
    dado_d         = dado_q;
    lane_d         = lane_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (ReqValid && req_ready_q) begin
`ifdef ACESSO_SUBPALAVRA_EN
          escrita_d = ReqEscrita;
          tamanho_d = ReqTamanho;
          sinal_d   = ReqSinal;
          dado_d    = ReqDado;
          lane_d    = w_off[1:0];
`endif
          endereco_d  = w_indice;
          resp_dado_d = 32'h0;
          resp_erro_d = 1'b0;
          if (w_erro) begin
            resp_erro_d = 1'b1;
            estado_d    = RESPOSTA;
          end else if (ReqEscrita && (ReqTamanho == c_PALAVRA)) begin
            escreve_dado_d = ReqDado;
            estado_d       = ESCREVE;
          end else begin
            estado_d = LE;
          end
        end
      end
      LE: estado_d = CAPTURA;
      CAPTURA: begin
`ifdef ACESSO_SUBPALAVRA_EN
        if (escrita_q) begin
          escreve_dado_d = w_mesclado;
          estado_d       = ESCREVE;
        end else begin
          resp_dado_d = w_extraido;
          estado_d    = RESPOSTA;
        end
`else
        resp_dado_d = DadosLeitura;
        estado_d    = RESPOSTA;
`endif
      end
      ESCREVE: estado_d = RESPOSTA;
      RESPOSTA: begin
        if (RespReady) begin
          resp_dado_d = 32'h0;
          resp_erro_d = 1'b0;
          estado_d    = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    // Every handshake/strobe output is a registered decode of the next state.
    req_ready_d  = (estado_d == OCIOSO);
    read_mem_d   = (estado_d == LE);
    write_mem_d  = (estado_d == ESCREVE);
    resp_valid_d = (estado_d == RESPOSTA);
  end

  assign ReqReady    = req_ready_q;
  assign RespValid   = resp_valid_q;
  assign RespErro    = resp_erro_q;
  assign RespDado    = resp_dado_q;
  assign Endereco    = endereco_q;
  assign EscreveDado = escreve_dado_q;
  assign WriteMem    = write_mem_q;
  assign ReadMem     = read_mem_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_acesso_memoria.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_unidade_acesso_memoria                                     |
// | Purpose  : directed self-checking bench with a registered-read memory    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_unidade_acesso_memoria;

  logic        Clock;
  logic        Reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqEscrita;
  logic [1:0]  ReqTamanho;
  logic        ReqSinal;
  logic [31:0] ReqEndereco;
  logic [31:0] ReqDado;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespDado;
  logic        RespErro;
  logic [31:0] Endereco;
  logic [31:0] EscreveDado;
  logic        WriteMem;
  logic        ReadMem;
  logic [31:0] DadosLeitura;

  int n_assert = 0;
  int n_fail   = 0;

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  logic [31:0] mem [0:15];

  unidade_acesso_memoria #(
    .PROFUNDIDADE (16),
    .ENDERECO_BASE(32'h0)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .ReqValid    (ReqValid),
    .ReqReady    (ReqReady),
    .ReqEscrita  (ReqEscrita),
    .ReqTamanho  (ReqTamanho),
    .ReqSinal    (ReqSinal),
    .ReqEndereco (ReqEndereco),
    .ReqDado     (ReqDado),
    .RespValid   (RespValid),
    .RespReady   (RespReady),
    .RespDado    (RespDado),
    .RespErro    (RespErro),
    .Endereco    (Endereco),
    .EscreveDado (EscreveDado),
    .WriteMem    (WriteMem),
    .ReadMem     (ReadMem),
    .DadosLeitura(DadosLeitura)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Word-addressed memory with one-cycle registered read.
  always @(posedge Clock) begin
    if (WriteMem && (Endereco < 32'd16)) mem[Endereco[3:0]] <= EscreveDado;
    if (ReadMem) DadosLeitura <= (Endereco < 32'd16) ? mem[Endereco[3:0]] : 32'h0;
  end

  always @(negedge Clock) begin
    if (WriteMem) begin
      wr_cnt++;
      last_wr_addr = Endereco;
      last_wr_data = EscreveDado;
    end
    if (ReadMem) rd_cnt++;
    if (WriteMem && ReadMem) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic esc, input logic [1:0] tam, input logic sin,
                     input logic [31:0] addr, input logic [31:0] dado,
                     output int lat, output logic [31:0] rd, output logic er);
    @(negedge Clock);
    ReqValid    = 1'b1;
    ReqEscrita  = esc;
    ReqTamanho  = tam;
    ReqSinal    = sin;
    ReqEndereco = addr;
    ReqDado     = dado;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    lat = 99;
    rd  = 32'hx;
    er  = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clock);
      if (RespValid) begin
        lat = i;
        rd  = RespDado;
        er  = RespErro;
        break;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          wr0, rd0;

  initial begin
    Reset_n     = 1'b0;
    ReqValid    = 1'b0;
    ReqEscrita  = 1'b0;
    ReqTamanho  = 2'b10;
    ReqSinal    = 1'b0;
    ReqEndereco = 32'h0;
    ReqDado     = 32'h0;
    RespReady   = 1'b1;

    repeat (2) @(negedge Clock);
    chk("rst_ReqReady", {31'h0, ReqReady}, 32'h1);
    chk("rst_RespValid", {31'h0, RespValid}, 32'h0);
    chk("rst_RespErro", {31'h0, RespErro}, 32'h0);
    chk("rst_strobes", {30'h0, WriteMem, ReadMem}, 32'h0);
    chk("rst_RespDado", RespDado, 32'h0);
    chk("rst_Endereco", Endereco, 32'h0);
    chk("rst_EscreveDado", EscreveDado, 32'h0);
    Reset_n = 1'b1;

    // Word store then word load at 0x8
    wr0 = wr_cnt; rd0 = rd_cnt;
    req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, er);
    chk("st8_lat", 32'(lat), 32'd2);
    chk("st8_erro", {31'h0, er}, 32'h0);
    chk("st8_wrcnt", 32'(wr_cnt - wr0), 32'd1);
    chk("st8_rdcnt", 32'(rd_cnt - rd0), 32'd0);
    chk("st8_addr", last_wr_addr, 32'd2);
    chk("st8_data", last_wr_data, 32'hDEADBEEF);
    chk("st8_ready", {31'h0, ReqReady}, 32'h1);

    rd0 = rd_cnt;
    req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, er);
    chk("ld8_lat", 32'(lat), 32'd3);
    chk("ld8_data", rd, 32'hDEADBEEF);
    chk("ld8_erro", {31'h0, er}, 32'h0);
    chk("ld8_rdcnt", 32'(rd_cnt - rd0), 32'd1);

    // Preload word 3 and word 1 through the DUT
    req(1'b1, 2'b10, 1'b0, 32'hC, 32'h80FF7F01, lat, rd, er);
    chk("st_w3_lat", 32'(lat), 32'd2);
    req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, lat, rd, er);
    chk("st_w1_lat", 32'(lat), 32'd2);

    // Sub-word loads from word 3
    wr0 = wr_cnt; rd0 = rd_cnt;
    req(1'b0, 2'b00, 1'b1, 32'hD, 32'h0, lat, rd, er);
`ifdef ACESSO_SUBPALAVRA_EN
    chk("ldb_D_lat", 32'(lat), 32'd3);
    chk("ldb_D_data", rd, 32'h0000007F);
    chk("ldb_D_erro", {31'h0, er}, 32'h0);
`else
    chk("ldb_D_lat", 32'(lat), 32'd1);
    chk("ldb_D_data", rd, 32'h0);
    chk("ldb_D_erro", {31'h0, er}, 32'h1);
`endif
    req(1'b0, 2'b00, 1'b1, 32'hE, 32'h0, lat, rd, er);
`ifdef ACESSO_SUBPALAVRA_EN
    chk("ldb_E_data", rd, 32'hFFFFFFFF);
    chk("ldb_E_erro", {31'h0, er}, 32'h0);
`else
    chk("ldb_E_data", rd, 32'h0);
    chk("ldb_E_erro", {31'h0, er}, 32'h1);
`endif
    req(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, lat, rd, er);
`ifdef ACESSO_SUBPALAVRA_EN
    chk("ldh_E_data", rd, 32'h000080FF);
    chk("ldh_E_erro", {31'h0, er}, 32'h0);
    chk("ld_sub_rdcnt", 32'(rd_cnt - rd0), 32'd3);
`else
    chk("ldh_E_data", rd, 32'h0);
    chk("ldh_E_erro", {31'h0, er}, 32'h1);
    chk("ld_sub_rdcnt", 32'(rd_cnt - rd0), 32'd0);
`endif
    chk("ld_sub_wrcnt", 32'(wr_cnt - wr0), 32'd0);

    // Byte store 0xAA at 0x5 over 0x11223344
    wr0 = wr_cnt; rd0 = rd_cnt;
    req(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AA, lat, rd, er);
`ifdef ACESSO_SUBPALAVRA_EN
    chk("stb_lat", 32'(lat), 32'd4);
    chk("stb_erro", {31'h0, er}, 32'h0);
    chk("stb_rdcnt", 32'(rd_cnt - rd0), 32'd1);
    chk("stb_wrcnt", 32'(wr_cnt - wr0), 32'd1);
    chk("stb_addr", last_wr_addr, 32'd1);
    chk("stb_data", last_wr_data, 32'h1122AA44);
`else
    chk("stb_lat", 32'(lat), 32'd1);
    chk("stb_erro", {31'h0, er}, 32'h1);
    chk("stb_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
`endif
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rd, er);
`ifdef ACESSO_SUBPALAVRA_EN
    chk("ld_w1_data", rd, 32'h1122AA44);
`else
    chk("ld_w1_data", rd, 32'h11223344);
`endif

    // Error cases: no strobes, zero data, immediate response
    wr0 = wr_cnt; rd0 = rd_cnt;
    req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rd, er);
    chk("err_w6_erro", {31'h0, er}, 32'h1);
    chk("err_w6_data", rd, 32'h0);
    chk("err_w6_lat", 32'(lat), 32'd1);
    req(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, lat, rd, er);
    chk("err_h3_erro", {31'h0, er}, 32'h1);
    chk("err_h3_data", rd, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
    chk("err_w40_erro", {31'h0, er}, 32'h1);
    chk("err_w40_data", rd, 32'h0);
    req(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, lat, rd, er);
    chk("err_sz11_erro", {31'h0, er}, 32'h1);
    chk("err_sz11_data", rd, 32'h0);
    chk("err_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

    // Back-pressure on the response channel
    RespReady = 1'b0;
    @(negedge Clock);
    ReqValid = 1'b1; ReqEscrita = 1'b0; ReqTamanho = 2'b10; ReqEndereco = 32'h8;
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clock);
      if (RespValid) begin
        lat = i;
        break;
      end
    end
    chk("bp_lat", 32'(lat), 32'd3);
    ReqValid = 1'b1; ReqEscrita = 1'b1; ReqTamanho = 2'b10; ReqEndereco = 32'h0;
    ReqDado = 32'hCAFEF00D;
    wr0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("bp_valid", {31'h0, RespValid}, 32'h1);
      chk("bp_data", RespDado, 32'hDEADBEEF);
      chk("bp_ready", {31'h0, ReqReady}, 32'h0);
    end
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    @(posedge Clock);
    #1;
    chk("bp_rel_ready", {31'h0, ReqReady}, 32'h1);
    chk("bp_rel_valid", {31'h0, RespValid}, 32'h0);
    chk("bp_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Asynchronous reset during ESCREVE
    @(negedge Clock);
    ReqValid = 1'b1; ReqEscrita = 1'b1; ReqEndereco = 32'h4; ReqDado = 32'h55;
`ifdef ACESSO_SUBPALAVRA_EN
    ReqTamanho = 2'b00;
`else
    ReqTamanho = 2'b10;
`endif
    @(posedge Clock);
    #1 ReqValid = 1'b0;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clock);
      if (WriteMem) begin
        lat = i;
        break;
      end
    end
`ifdef ACESSO_SUBPALAVRA_EN
    chk("rst_mid_wr_cycle", 32'(lat), 32'd3);
`else
    chk("rst_mid_wr_cycle", 32'(lat), 32'd1);
`endif
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_mid_wm", {31'h0, WriteMem}, 32'h0);
    chk("rst_mid_valid", {31'h0, RespValid}, 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_mid_ready", {31'h0, ReqReady}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("rst_mid_noresp", {31'h0, RespValid}, 32'h0);
    end

    chk("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
